// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request: req/ready handshake, then one rvalid beat.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage. Owns the PC, issues one word request at a
// time to imem, presents fetched words to decode, buffers one extra word
// under stall, and absorbs redirects (killing an in-flight response).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  inst_out,
  output logic [31:0]  pc_out,
  output logic         valid_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // ready to issue a request at pc
    S_WAIT  = 2'd1,  // request accepted, response outstanding
    S_HOLD  = 2'd2   // response parked in the pending buffer
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] req_pc, req_pc_d;
  logic [31:0] pend_inst, pend_inst_d;
  logic [31:0] pend_pc, pend_pc_d;
  logic        kill, kill_d;
  logic [31:0] inst_d, pc_out_d;
  logic        valid_d;

  logic        accept;
  logic        slot_free;
  logic [31:0] target;

  // Redirect targets are always word aligned; the low bits are masked off.
  assign target    = redirect_pc & ~32'h3;
  assign slot_free = !valid_out || !stall;

  // Request is decoded combinationally: only in FETCH, never in a redirect
  // cycle, and never while reset is held.
  assign imem.imem_req  = (state == S_FETCH) && !redirect && !rst;
  assign imem.imem_addr = pc;
  assign accept         = imem.imem_req && imem.imem_ready;

  // Next-state and next-register values for the whole fetch stage.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state;
    pc_d        = pc;
    req_pc_d    = req_pc;
    pend_inst_d = pend_inst;
    pend_pc_d   = pend_pc;
    kill_d      = kill;
    inst_d      = inst_out;
    pc_out_d    = pc_out;
    valid_d     = valid_out;

    // Decode takes the current word; a load below may refill the slot.
    if (valid_out && !stall) valid_d = 1'b0;

    if (redirect) begin
      pc_d        = target;
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
      pend_inst_d = NOP_INST;
      pend_pc_d   = 32'h0;
      if (state == S_WAIT && !imem.imem_rvalid) begin
        // Response still in flight: remember to drop it when it lands.
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) begin
            req_pc_d = pc;
            pc_d     = pc + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else if (slot_free) begin
              inst_d   = imem.imem_rdata;
              pc_out_d = req_pc;
              valid_d  = 1'b1;
              state_d  = S_FETCH;
            end else begin
              pend_inst_d = imem.imem_rdata;
              pend_pc_d   = req_pc;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_d   = pend_inst;
            pc_out_d = pend_pc;
            valid_d  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and datapath registers; reset may hit mid-request.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      req_pc    <= 32'h0;
      pend_inst <= NOP_INST;
      pend_pc   <= 32'h0;
      kill      <= 1'b0;
      inst_out  <= NOP_INST;
      pc_out    <= 32'h0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      req_pc    <= req_pc_d;
      pend_inst <= pend_inst_d;
      pend_pc   <= pend_pc_d;
      kill      <= kill_d;
      inst_out  <= inst_d;
      pc_out    <= pc_out_d;
      valid_out <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios followed by
// randomized stall/redirect/ready/latency traffic. Expected behaviour comes
// from a program-order scoreboard (next delivered PC is previous + 4, or the
// redirect target) and an address-derived memory image.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: two fixed words for the reset scenario, otherwise derived
  // from the address so every location is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100)      return 32'h00A0_0093;
    else if (a == 32'h0000_0104) return 32'h0010_0113;
    else                         return a ^ 32'hC0DE_0003;
  endfunction

  // Memory responder state.
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;
  logic [31:0] mem_addr = 32'h0;

  // Values sampled during the most recent cycle.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  // Scoreboard.
  logic [31:0] exp_pc        = RESET_PC;
  logic        exp_hold      = 1'b0;
  logic        exp_flush     = 1'b0;
  logic        exp_addr_hold = 1'b0;
  logic [31:0] hold_inst, hold_pc, held_addr;
  logic        rand_mode     = 1'b0;
  int          delivered     = 0;

  // One clock cycle: drive at the falling edge, sample, score, update memory.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic accepted;
    @(negedge clk);
    bus.imem_rvalid = mem_busy && (mem_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? mem_word(mem_addr) : $urandom;
    bus.imem_ready  = rdy;
    stall           = st;
    redirect        = rd;
    redirect_pc     = rpc;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = valid_out;
    s_inst  = inst_out;
    s_pc    = pc_out;

    if (exp_hold) begin
      check("stall_hold_valid", 32'(s_valid), 32'd1);
      check("stall_hold_inst", s_inst, hold_inst);
      check("stall_hold_pc", s_pc, hold_pc);
    end
    if (exp_flush) check("redirect_flush_valid", 32'(s_valid), 32'd0);
    if (exp_addr_hold) check("req_addr_stable", s_addr, held_addr);
    exp_hold      = 1'b0;
    exp_flush     = 1'b0;
    exp_addr_hold = 1'b0;

    if (rand_mode && mem_busy) check("single_outstanding", 32'(s_req), 32'd0);

    if (s_valid && !st) begin
      check("deliver_pc", s_pc, exp_pc);
      check("deliver_inst", s_inst, mem_word(s_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (rd) begin
      exp_pc    = {rpc[31:2], 2'b00};
      exp_flush = 1'b1;
    end else if (s_valid && st) begin
      exp_hold  = 1'b1;
      hold_inst = s_inst;
      hold_pc   = s_pc;
    end
    if (s_req && !rdy) begin
      exp_addr_hold = 1'b1;
      held_addr     = s_addr;
    end

    accepted = s_req && rdy;
    if (bus.imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (accepted) begin
      check("req_addr_aligned", 32'(s_addr[1:0]), 32'd0);
      mem_busy = 1'b1;
      mem_cnt  = mem_lat - 1;
      mem_addr = s_addr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 32'(bus.imem_req), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_inst", inst_out, NOP_INST);
    check("reset_pc_out", pc_out, 32'h0);
    #1 rst = 1'b0;

    // Reset release, zero-wait memory.
    mem_lat = 1;
    cycle(0, 0, 32'h0, 1);                                  // c0
    check("c0_req", 32'(s_req), 32'd1);
    check("c0_addr", s_addr, 32'h100);
    cycle(0, 0, 32'h0, 1);                                  // c1
    check("c1_req", 32'(s_req), 32'd0);
    cycle(1, 0, 32'h0, 1);                                  // c2 stall begins
    check("c2_addr", s_addr, 32'h104);
    check("c2_valid", 32'(s_valid), 32'd1);
    check("c2_inst", s_inst, 32'h00A0_0093);
    check("c2_pc", s_pc, 32'h100);
    cycle(1, 0, 32'h0, 1);                                  // c3 word 0x104 buffered
    check("c3_inst", s_inst, 32'h00A0_0093);
    cycle(1, 0, 32'h0, 1);                                  // c4
    check("c4_pc", s_pc, 32'h100);
    cycle(0, 0, 32'h0, 1);                                  // c5 stall dropped
    check("c5_pc", s_pc, 32'h100);
    mem_lat = 3;
    cycle(0, 0, 32'h0, 1);                                  // c6
    check("c6_pc", s_pc, 32'h104);
    check("c6_inst", s_inst, 32'h0010_0113);
    check("c6_addr", s_addr, 32'h108);

    // Redirect while waiting on a slow response.
    cycle(0, 1, 32'h203, 1);                                // c7
    for (int c = 8; c <= 13; c++) begin
      cycle(0, 0, 32'h0, 1);
      check("kill_valid_low", 32'(s_valid), 32'd0);
      if (c == 10) begin
        check("redirect_req", 32'(s_req), 32'd1);
        check("redirect_addr", s_addr, 32'h200);
      end
    end
    mem_lat = 1;
    cycle(1, 0, 32'h0, 1);                                  // c14
    check("c14_valid", 32'(s_valid), 32'd1);
    check("c14_pc", s_pc, 32'h200);

    // Redirect and stall together while a word is pending.
    cycle(1, 0, 32'h0, 1);                                  // c15
    cycle(1, 1, 32'h300, 1);                                // c16
    cycle(0, 0, 32'h0, 1);                                  // c17
    check("c17_valid", 32'(s_valid), 32'd0);
    check("c17_addr", s_addr, 32'h300);
    cycle(0, 0, 32'h0, 1);                                  // c18

    // Memory not ready for four cycles.
    for (int c = 19; c <= 22; c++) begin
      cycle(0, 0, 32'h0, 0);
      check("nready_req", 32'(s_req), 32'd1);
      check("nready_addr", s_addr, 32'h304);
    end
    cycle(0, 0, 32'h0, 1);                                  // c23 accept
    cycle(0, 0, 32'h0, 1);                                  // c24
    cycle(0, 0, 32'h0, 1);                                  // c25
    check("c25_addr", s_addr, 32'h308);
    check("c25_pc", s_pc, 32'h304);
    cycle(0, 0, 32'h0, 1);                                  // c26

    // Wrap at the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFF, 1);                          // c27
    cycle(0, 0, 32'h0, 1);                                  // c28
    check("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 1);                                  // c29
    mem_lat = 2;
    cycle(1, 0, 32'h0, 1);                                  // c30
    check("wrap_zero_addr", s_addr, 32'h0);
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);

    // Asynchronous reset pulse in the middle of WAIT.
    #1 rst = 1'b1;
    #1;
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_inst", inst_out, NOP_INST);
    check("async_pc_out", pc_out, 32'h0);
    check("async_req", 32'(bus.imem_req), 32'd0);
    rst       = 1'b0;
    exp_pc    = RESET_PC;
    exp_hold  = 1'b0;
    exp_flush = 1'b0;
    exp_addr_hold = 1'b0;
    cycle(0, 0, 32'h0, 0);                                  // c31
    check("rst_restart_addr", s_addr, RESET_PC);
    mem_lat = 1;
    cycle(0, 0, 32'h0, 1);                                  // c32 stale rvalid
    check("stale_req", 32'(s_req), 32'd1);
    cycle(0, 0, 32'h0, 1);                                  // c33
    check("stale_ignored", 32'(s_valid), 32'd0);
    cycle(0, 0, 32'h0, 1);                                  // c34
    check("restart_pc", s_pc, RESET_PC);
    check("restart_inst", s_inst, 32'h00A0_0093);

    // Randomized traffic against the scoreboard.
    rand_mode = 1'b1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        st, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom % 100) < 30;
      rd  = ($urandom % 100) < 5;
      rdy = ($urandom % 100) < 70;
      rpc = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 4096);
      mem_lat = 1 + int'($urandom % 3);
      cycle(st, rd, rpc, rdy);
    end
    check("random_progress", 32'(delivered > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline, and the producer side of the decode interface. It owns the program counter and issues word requests to instruction memory over a single-outstanding request/response handshake. It presents each fetched word with its PC and a valid flag to the decode stage, which feeds the opcode, funct3, funct7 and valid fields into `controlunit`. It also honours decode-stage stalls and absorbs branch/jump redirects, including discarding a response that was already in flight.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: value driven on `inst_out` after reset and after a flush (addi x0,x0,0).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: decode cannot accept; hold the current output.
- `redirect` input 1: taken branch, jal or jalr resolved; flush and refetch.
- `redirect_pc` input 32: new fetch target; bits [1:0] are ignored and forced to 0.
- `imem_req` output 1: request valid.
- `imem_addr` output 32: word address of the request (bits [1:0] = 0).
- `imem_ready` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: response word present.
- `imem_rdata` input 32: response instruction word.
- `inst_out` output 32: instruction to decode.
- `pc_out` output 32: PC of `inst_out`.
- `valid_out` output 1: `inst_out`/`pc_out` are valid.

## Operation
- Registers:
  - `pc`: next request address.
  - `req_pc`: PC of the request in flight.
  - output slot: `inst_out`, `pc_out`, `valid_out`.
  - pending buffer: `pend_inst`, `pend_pc`.
  - `kill` flag.
  - 2-bit state.
- Request accepted when `imem_req & imem_ready`. Decode consumes when `valid_out & !stall`.
- Slot free when `!valid_out | !stall`.
- States and transitions:
  - FETCH:
    - `imem_req = !redirect`, `imem_addr = pc`.
    - On accept: `req_pc <= pc`, `pc <= pc + 4` (mod 2^32, wraps silently), go WAIT.
  - WAIT:
    - `imem_req = 0`.
    - On `imem_rvalid` with `kill = 1`: drop the word, clear `kill`, go FETCH.
    - On `imem_rvalid` with `kill = 0` and slot free: load the slot with `imem_rdata`/`req_pc` and `valid_out = 1`, go FETCH.
    - On `imem_rvalid` with `kill = 0` and slot full: write the pending buffer, go HOLD.
    - `imem_rvalid` outside WAIT is ignored.
  - HOLD:
    - `imem_req = 0`.
    - When `!stall`: move the pending buffer into the slot, go FETCH.
- Decode consumption with no new word loaded that cycle: `valid_out <= 0`.
- Redirect (highest priority, any state):
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `valid_out <= 0`, `inst_out <= NOP_INST`; pending buffer is discarded.
  - In WAIT without a same-cycle `imem_rvalid`: set `kill`, stay in WAIT.
  - In WAIT with a same-cycle `imem_rvalid`: drop the word, go FETCH.
  - In FETCH or HOLD: go FETCH.
  - No request is issued in the redirect cycle.
- Redirect overrides `stall` in the same cycle.
- Reset (async, any state, including mid-request):
  - `pc = RESET_PC`, state FETCH, `kill = 0`.
  - `valid_out = 0`, `inst_out = NOP_INST`, `pc_out = 0`.
  - Pending buffer cleared.
  - `imem_req` is forced to 0 while `rst` is high.
  - A response arriving after reset release is ignored, because the state is FETCH.

## Timing
- Zero-wait memory (`imem_ready = 1`, `rvalid` one cycle after accept): request at cycle N, response at N+1, `valid_out` at N+2, next request at N+2. Sustained throughput is 1 instruction per 2 cycles.
- First request is issued in the first cycle after `rst` deasserts.
- Redirect asserted at cycle N: `valid_out = 0` from N+1. The request to `redirect_pc` is issued at N+1 if the state is FETCH. If a response is in flight, the request is issued the cycle after the killed response arrives.
- Stall holds all outputs stable. Fetching proceeds until the pending buffer is occupied; at most one word is buffered beyond the slot.
- All outputs are registered except `imem_req`/`imem_addr`, which decode from state, `pc`, `redirect` and `rst`.

## Test plan
- Reset release with `RESET_PC` = 0x100 and zero-wait memory returning `0x00A00093` at 0x100 and `0x00100113` at 0x104:
  - `imem_addr` = 0x100 at cycle 0, then 0x104 at cycle 2.
  - `inst_out` = 0x00A00093 with `pc_out` = 0x100 valid at cycle 2.
- Stall held 3 cycles while word 0x104 returns:
  - Word goes to the pending buffer; `inst_out` stays at the 0x100 word.
  - After the stall drops, `pc_out` = 0x104 next cycle, with no duplicate and no loss.
- Redirect to 0x203 while in WAIT with a 3-cycle memory latency:
  - Late response discarded.
  - Next `imem_addr` = 0x200.
  - `valid_out` = 0 until the 0x200 word arrives.
- Redirect and stall in the same cycle while holding a pending word:
  - `valid_out` = 0 next cycle; pending word dropped.
  - Fetch resumes at the target.
- `imem_ready` low for 4 cycles:
  - `imem_req` and `imem_addr` stay stable.
  - `pc` advances only on accept.
- Async `rst` pulse mid-WAIT:
  - Outputs go to reset values immediately.
  - The stale `rvalid` one cycle later is ignored.
  - Fetch restarts at `RESET_PC`.
  - `pc` = 0xFFFF_FFFC increments to 0x0000_0000 (wrap).
